// File: rtl/custom_bus_matrix_input_stage.sv
// Per-master input stage of the custom AHB bus matrix.
// Forwards the master's address phase to the decoder and output stages. Raises
// trans_pend toward the output arbiters. When the target output is not granted
// or not ready, the transfer is parked in a one-deep holding register and the
// master is stalled. The data-phase response is returned once this port owns
// a slave data phase.
module custom_bus_matrix_input_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // master-side address phase
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    // address phase toward decoder / output stages
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    // arbitration handshake with the output stage
    output logic              trans_pend,
    input  logic              active_trans,
    input  logic              HREADYM,
    input  logic              HRESPM
);

    logic              pend_r;
    logic              dphase_r;
    logic [ADDR_W-1:0] hold_addr_r;
    logic [1:0]        hold_trans_r;
    logic              hold_write_r;
    logic [2:0]        hold_size_r;
    logic [2:0]        hold_burst_r;
    logic [3:0]        hold_prot_r;
    logic              hold_lock_r;

    logic              new_req_s;
    logic              accept_s;

    // A NONSEQ/SEQ transfer is sampled only when the bus is ready.
    // The output stage takes the request when it has selected this port and is ready.
    assign new_req_s = HSELS & HTRANSS[1] & HREADYS;
    assign accept_s  = active_trans & HREADYM;

    // Address mux: a parked transfer takes priority over the live master signals.
    always_comb begin
        HSELM      = 1'b0;
        HADDRM     = {ADDR_W{1'b0}};
        HTRANSM    = 2'b00;
        HWRITEM    = 1'b0;
        HSIZEM     = 3'b000;
        HBURSTM    = 3'b000;
        HPROTM     = 4'b0000;
        HMASTLOCKM = 1'b0;
        if (pend_r) begin
            HSELM      = 1'b1;
            HADDRM     = hold_addr_r;
            HTRANSM    = hold_trans_r;
            HWRITEM    = hold_write_r;
            HSIZEM     = hold_size_r;
            HBURSTM    = hold_burst_r;
            HPROTM     = hold_prot_r;
            HMASTLOCKM = hold_lock_r;
        end else begin
            HSELM      = HSELS;
            HADDRM     = HADDRS;
            HTRANSM    = HTRANSS;
            HWRITEM    = HWRITES;
            HSIZEM     = HSIZES;
            HBURSTM    = HBURSTS;
            HPROTM     = HPROTS;
            HMASTLOCKM = HMASTLOCKS;
        end
    end

    // Ready/response back to the master: stall while parked, else follow the owned data phase.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        if (pend_r) begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b0;
        end else if (dphase_r) begin
            HREADYOUTS = HREADYM;
            HRESPS     = HRESPM;
        end else begin
            HREADYOUTS = 1'b1;
            HRESPS     = 1'b0;
        end
    end

    // The arbiter sees the request in the same cycle it appears on the master port.
    assign trans_pend = pend_r | new_req_s;

    // Holding register, pending flag and data-phase ownership flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_r       <= 1'b0;
            dphase_r     <= 1'b0;
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_trans_r <= 2'b00;
            hold_write_r <= 1'b0;
            hold_size_r  <= 3'b000;
            hold_burst_r <= 3'b000;
            hold_prot_r  <= 4'b0000;
            hold_lock_r  <= 1'b0;
        end else begin
            if (new_req_s) begin
                hold_addr_r  <= HADDRS;
                hold_trans_r <= HTRANSS;
                hold_write_r <= HWRITES;
                hold_size_r  <= HSIZES;
                hold_burst_r <= HBURSTS;
                hold_prot_r  <= HPROTS;
                hold_lock_r  <= HMASTLOCKS;
            end

            if (pend_r) begin
                pend_r <= ~accept_s;
            end else begin
                pend_r <= new_req_s & ~accept_s;
            end

            // A fresh accept keeps ownership even when the previous data phase ends now.
            if (accept_s & HTRANSM[1]) begin
                dphase_r <= 1'b1;
            end else if (HREADYM) begin
                dphase_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_custom_bus_matrix_input_stage.sv
// Directed testbench for custom_bus_matrix_input_stage.
// The bench changes the inputs 1 ns after each rising edge. It checks the
// outputs 1 ns later, before the next rising edge. HREADYS is driven as the
// bus would drive it, which is the value of HREADYOUTS expected in that cycle.
module tb_custom_bus_matrix_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        HSELM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;
    logic        trans_pend;
    logic        active_trans;
    logic        HREADYM;
    logic        HRESPM;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    custom_bus_matrix_input_stage #(.ADDR_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
        .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
        .trans_pend(trans_pend), .active_trans(active_trans),
        .HREADYM(HREADYM), .HRESPM(HRESPM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // Drive one master address phase and the output-stage handshake inputs.
    task automatic drv(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic rdys, input logic act, input logic rdym, input logic rspm);
        HSELS        = sel;
        HTRANSS      = trans;
        HADDRS       = addr;
        HREADYS      = rdys;
        active_trans = act;
        HREADYM      = rdym;
        HRESPM       = rspm;
        #1;
    endtask

    initial begin
        HRESETn    = 1'b0;
        HWRITES    = 1'b1;
        HSIZES     = 3'b010;
        HBURSTS    = 3'b000;
        HPROTS     = 4'b0011;
        HMASTLOCKS = 1'b0;
        drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset state.
        repeat (2) cyc();
        chk("rst_readyout", 64'(HREADYOUTS), 64'h1);
        chk("rst_resp",     64'(HRESPS),     64'h0);
        chk("rst_pend",     64'(trans_pend), 64'h0);
        chk("rst_htransm",  64'(HTRANSM),    64'h0);
        chk("rst_hselm",    64'(HSELM),      64'h0);
        HRESETn = 1'b1;

        // Zero-latency path to 0x1000.
        cyc(); drv(1'b1, 2'b10, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("zl_addr",      64'(HADDRM),     64'h1000);
        chk("zl_pend",      64'(trans_pend), 64'h1);
        chk("zl_readyout0", 64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("zl_readyout1", 64'(HREADYOUTS), 64'h1);
        chk("zl_nopend",    64'(trans_pend), 64'h0);

        // Denied transfer to 0x2000, parked while the master shows 0x3000.
        cyc(); drv(1'b1, 2'b10, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("den_addr0",     64'(HADDRM),     64'h2000);
        chk("den_readyout0", 64'(HREADYOUTS), 64'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(1'b1, 2'b10, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("den_hold_addr", 64'(HADDRM),     64'h2000);
            chk("den_hold_pend", 64'(trans_pend), 64'h1);
            chk("den_hold_rdy",  64'(HREADYOUTS), 64'h0);
            chk("den_hold_tr",   64'(HTRANSM),    64'h2);
            chk("den_hold_sel",  64'(HSELM),      64'h1);
        end
        cyc(); drv(1'b1, 2'b10, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("den_acc_addr", 64'(HADDRM),     64'h2000);
        chk("den_acc_rdy",  64'(HREADYOUTS), 64'h0);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("den_dp_rdy0",  64'(HREADYOUTS), 64'h0);
        chk("den_dp_pend",  64'(trans_pend), 64'h0);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("den_dp_rdy1",  64'(HREADYOUTS), 64'h1);

        // INCR4 burst with two wait states on the data phase of beat 2.
        HBURSTS = 3'b011;
        cyc(); drv(1'b1, 2'b10, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b1_addr", 64'(HADDRM),     64'h100);
        chk("b1_rdy",  64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b1, 2'b11, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2_addr", 64'(HADDRM),     64'h104);
        chk("b2_tr",   64'(HTRANSM),    64'h3);
        chk("b2_rdy",  64'(HREADYOUTS), 64'h1);
        for (int i = 0; i < 2; i++) begin
            cyc(); drv(1'b1, 2'b11, 32'h108, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("bw_rdy", 64'(HREADYOUTS), 64'h0);
        end
        cyc(); drv(1'b1, 2'b11, 32'h108, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b3_addr", 64'(HADDRM),     64'h108);
        chk("b3_rdy",  64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b1, 2'b11, 32'h10C, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b4_addr", 64'(HADDRM),     64'h10C);
        chk("b4_rdy",  64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("bend_rdy",  64'(HREADYOUTS), 64'h1);
        chk("bend_pend", 64'(trans_pend), 64'h0);
        HBURSTS = 3'b000;

        // Two-cycle ERROR response.
        cyc(); drv(1'b1, 2'b10, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("er_acc_rdy", 64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("er1_resp", 64'(HRESPS),     64'h1);
        chk("er1_rdy",  64'(HREADYOUTS), 64'h0);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("er2_resp", 64'(HRESPS),     64'h1);
        chk("er2_rdy",  64'(HREADYOUTS), 64'h1);
        cyc(); drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("er_idle_resp", 64'(HRESPS),     64'h0);
        chk("er_idle_rdy",  64'(HREADYOUTS), 64'h1);

        // Asynchronous reset while a transfer is parked.
        cyc(); drv(1'b1, 2'b10, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); drv(1'b1, 2'b10, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rp_pend", 64'(trans_pend), 64'h1);
        chk("rp_rdy",  64'(HREADYOUTS), 64'h0);
        HRESETn = 1'b0;
        #1;
        chk("rp_rst_pend", 64'(trans_pend), 64'h0);
        chk("rp_rst_rdy",  64'(HREADYOUTS), 64'h1);
        drv(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        HRESETn = 1'b1;
        cyc();
        chk("rp_post_pend", 64'(trans_pend), 64'h0);
        chk("rp_post_sel",  64'(HSELM),      64'h0);
        chk("rp_post_tr",   64'(HTRANSM),    64'h0);
        cyc();
        chk("rp_post_rdy",  64'(HREADYOUTS), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
